ahb_slave_if_gen2: RTL and testbench

- Parametrised second-generation AHB slave front end for the AHB-to-APB bridge.
- Decodes NSEL contiguous equal-size APB regions and generates `valid` plus the one-hot select for the APB controller FSM.
- Pipelines address, write data and direction through a configurable-depth stall-aware register chain.
- Adds the AHB two-cycle ERROR response for unmapped, misaligned or APB-errored transfers (PSLVERR).

---
 rtl/bridge_pkg.sv | 27 ++
 rtl/ahb_pipe_stage.sv | 24 ++
 rtl/ahb_slave_if_gen2.sv | 135 +++++++++++++
 tb/tb_ahb_slave_if_gen2.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared constants, types and helpers for the AHB-to-APB bridge.
// Used by the AHB slave front end and its pipeline stages.
package bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } err_state_t;

  function automatic logic [31:0] region_idx(
    input logic [63:0] addr,
    input logic [63:0] base,
    input int unsigned lg
  );
    return 32'((addr - base) >> lg);
  endfunction

endpackage

// File: rtl/ahb_pipe_stage.sv
// One enable-gated register of the address/data/direction chain.
// Holds its contents whenever the enable is low.
module ahb_pipe_stage #(
  parameter int W = 65
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_q <= '0;
    else if (i_en)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ahb_slave_if_gen2.sv
// AHB slave front end: region decode, alignment check, stall-aware
// pipeline and the two-cycle AHB ERROR response.
module ahb_slave_if_gen2
  import bridge_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NSEL       = 3,
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
  parameter int                RGN_LOG2   = 26,
  parameter int                PIPE_DEPTH = 2
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [2:0]        Hsize,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pslverr_in,
  output logic              valid,
  output logic [NSEL-1:0]   tempselx,
  output logic [ADDR_W-1:0] Haddr1,
  output logic [ADDR_W-1:0] HaddrN,
  output logic [DATA_W-1:0] Hwdata1,
  output logic [DATA_W-1:0] HwdataN,
  output logic              Hwritereg,
  output logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Hresp,
  output logic              Hreadyout
);

  localparam int          W        = DATA_W + ADDR_W + 1;
  localparam logic [63:0] SPAN     = 64'(NSEL) << RGN_LOG2;
  localparam logic [63:0] LIMIT    = 64'(BASE) + SPAN;
  localparam logic [2:0]  MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

  if (LIMIT > (64'd1 << ADDR_W)) begin : g_bad_map
    $error("region map exceeds address space");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_dw
    $error("DATA_W must be 32 or 64");
  end
  if (PIPE_DEPTH < 1) begin : g_bad_depth
    $error("PIPE_DEPTH must be at least 1");
  end

  logic [63:0]       w_addr64;
  logic [31:0]       w_idx;
  logic [ADDR_W-1:0] w_mask;
  logic              w_mapped;
  logic              w_aligned;
  logic              w_active;
  logic              w_bad;
  logic [NSEL-1:0]   w_sel;

  assign w_addr64  = 64'(Haddr);
  assign w_mapped  = (w_addr64 >= 64'(BASE)) && (w_addr64 < LIMIT);
  assign w_idx     = region_idx(w_addr64, 64'(BASE), RGN_LOG2);
  assign w_mask    = ~({ADDR_W{1'b1}} << Hsize);
  assign w_aligned = (Hsize <= MAX_SIZE) && ((Haddr & w_mask) == '0);
  assign w_active  = Hreadyin &&
                     (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);
  assign w_bad     = w_active && !(w_mapped && w_aligned);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NSEL; i++)
      if (!Hreset && w_mapped && w_idx == 32'(i))
        w_sel[i] = 1'b1;
  end

  assign tempselx = w_sel;

  err_state_t r_state;
  err_state_t w_next;

  always_ff @(posedge Hclk) begin
    if (Hreset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Errors raised while already responding are dropped, not queued
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_bad || Pslverr_in) w_next = ERR1;
      ERR1:    w_next = ERR2;
      ERR2:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    Hresp     = HRESP_OKAY;
    Hreadyout = 1'b1;
    case (r_state)
      ERR1: begin
        Hresp     = HRESP_ERROR;
        Hreadyout = 1'b0;
      end
      ERR2: Hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign valid = !Hreset && w_active && w_mapped && w_aligned &&
                 (r_state == IDLE);

  logic [PIPE_DEPTH:0][W-1:0] w_chain;

  assign w_chain[0] = {Hwrite, Haddr, Hwdata};

  for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_pipe
    ahb_pipe_stage #(.W(W)) u_stage (
      .i_clk (Hclk),
      .i_rst (Hreset),
      .i_en  (Hreadyin),
      .i_d   (w_chain[k-1]),
      .o_q   (w_chain[k])
    );
  end

  assign Haddr1    = w_chain[1][DATA_W +: ADDR_W];
  assign Hwdata1   = w_chain[1][DATA_W-1:0];
  assign HaddrN    = w_chain[PIPE_DEPTH][DATA_W +: ADDR_W];
  assign HwdataN   = w_chain[PIPE_DEPTH][DATA_W-1:0];
  assign Hwritereg = w_chain[PIPE_DEPTH][W-1];
  assign Hrdata    = Prdata;

endmodule

// File: tb/tb_ahb_slave_if_gen2.sv
// Scoreboard bench for ahb_slave_if_gen2 with a behavioural model
// of decode, error countdown and beat history.
module tb_ahb_slave_if_gen2;

  localparam longint unsigned M_BASE = 64'h8000_0000;
  localparam longint unsigned M_RGN  = 64'h0400_0000;
  localparam longint unsigned M_LIM  = M_BASE + 3 * M_RGN;

  logic        clk = 1'b0;
  logic        Hreset = 1'b1;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b1;
  logic [1:0]  Htrans = 2'b00;
  logic [2:0]  Hsize = 3'd0;
  logic [31:0] Haddr = '0;
  logic [31:0] Hwdata = '0;
  logic [31:0] Prdata = '0;
  logic        Pslverr_in = 1'b0;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, HaddrN, Hwdata1, HwdataN, Hrdata;
  logic        Hwritereg;
  logic [1:0]  Hresp;
  logic        Hreadyout;

  ahb_slave_if_gen2 dut (
    .Hclk(clk), .Hreset(Hreset), .Hwrite(Hwrite),
    .Hreadyin(Hreadyin), .Htrans(Htrans), .Hsize(Hsize),
    .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .Pslverr_in(Pslverr_in), .valid(valid), .tempselx(tempselx),
    .Haddr1(Haddr1), .HaddrN(HaddrN), .Hwdata1(Hwdata1),
    .HwdataN(HwdataN), .Hwritereg(Hwritereg), .Hrdata(Hrdata),
    .Hresp(Hresp), .Hreadyout(Hreadyout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  sel;
    logic [1:0]  resp;
    logic        rdy;
    logic [31:0] a1, an, d1, dn, rdata;
    logic        wreg;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } beat_t;

  exp_t  sb[$];
  beat_t hist[$];
  int    err_cnt = 0;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("valid", valid, e.valid);
      chk("tempselx", tempselx, e.sel);
      chk("Hresp", Hresp, e.resp);
      chk("Hreadyout", Hreadyout, e.rdy);
      chk("Haddr1", Haddr1, e.a1);
      chk("HaddrN", HaddrN, e.an);
      chk("Hwdata1", Hwdata1, e.d1);
      chk("HwdataN", HwdataN, e.dn);
      chk("Hwritereg", Hwritereg, e.wreg);
      chk("Hrdata", Hrdata, e.rdata);
    end
  end

  task automatic cyc(input logic rst, input logic rdy,
                     input logic [1:0] tr, input logic [2:0] sz,
                     input logic [31:0] a, input logic wr,
                     input logic [31:0] wd, input logic perr);
    exp_t   e;
    beat_t  b;
    bit     mapped, algn, act;
    longint unsigned la;
    @(posedge clk);
    #1;
    Hreset = rst; Hreadyin = rdy; Htrans = tr; Hsize = sz;
    Haddr = a; Hwrite = wr; Hwdata = wd; Pslverr_in = perr;
    Prdata = $urandom;
    la     = longint'(a);
    mapped = (la >= M_BASE) && (la < M_LIM);
    algn   = (sz <= 3'd2) && ((la % (64'd1 << sz)) == 0);
    act    = rdy && (tr == 2'b10 || tr == 2'b11);
    e.valid = !rst && act && mapped && algn && (err_cnt == 0);
    e.sel   = (!rst && mapped) ? 3'(1 << ((la - M_BASE) / M_RGN)) : 3'b000;
    e.resp  = (err_cnt > 0) ? 2'b01 : 2'b00;
    e.rdy   = (err_cnt != 2);
    e.a1    = (hist.size() > 0) ? hist[0].addr : '0;
    e.d1    = (hist.size() > 0) ? hist[0].data : '0;
    e.an    = (hist.size() > 1) ? hist[1].addr : '0;
    e.dn    = (hist.size() > 1) ? hist[1].data : '0;
    e.wreg  = (hist.size() > 1) ? hist[1].wr   : 1'b0;
    e.rdata = Prdata;
    sb.push_back(e);
    if (rst) begin
      err_cnt = 0;
      hist.delete();
    end else begin
      if (err_cnt > 0)
        err_cnt--;
      else if ((act && !(mapped && algn)) || perr)
        err_cnt = 2;
      if (rdy) begin
        b.addr = a; b.data = wd; b.wr = wr;
        hist.push_front(b);
        if (hist.size() > 2) void'(hist.pop_back());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b1, 2'b00, 3'd0, $urandom, 1'b0, $urandom, 1'b0);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h8BFF_FFFC;
      2: return 32'h8C00_0000;
      3: return 32'h7FFF_FFFC;
      4: return r;
      default: return 32'h8000_0000 + (r % 32'h0C00_0000);
    endcase
  endfunction

  initial begin
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 2'b10, 3'd2, 32'h8400_0010, 1'b1, $urandom, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 3'd2, 32'h8400_0010, 1'b1, 32'hCAFE_0001, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 3'd2, 32'h0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 3'd2, 32'h0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 3'd2, 32'h9000_0000, 1'b0, $urandom, 1'b0);
    idle(3);
    cyc(1'b0, 1'b1, 2'b10, 3'd2, 32'h8000_0002, 1'b0, $urandom, 1'b0);
    idle(3);
    cyc(1'b0, 1'b1, 2'b10, 3'd1, 32'h8000_0002, 1'b0, $urandom, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 3'd2, 32'h9000_0001, 1'b0, $urandom, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 2'b10, 3'd2, $urandom, 1'b1, $urandom, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 3'd2, 32'h9000_0000, 1'b0, $urandom, 1'b1);
    idle(4);
    cyc(1'b0, 1'b1, 2'b11, 3'd3, 32'h8000_0000, 1'b0, $urandom, 1'b0);
    cyc(1'b1, 1'b1, 2'b00, 3'd0, 32'h0, 1'b0, $urandom, 1'b0);
    idle(2);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 9) != 0,
          2'($urandom_range(0, 3)),
          3'($urandom_range(0, 3)),
          pick_addr(),
          1'($urandom),
          $urandom,
          $urandom_range(0, 19) == 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
